// File: rtl/jcnt_sched_pkg.sv
// Johnson-code helpers shared by the slot timer and the capture scheduler.
// Codes are carried zero-padded to JW bits; n gives the active counter width.
package jcnt_sched_pkg;

    localparam int unsigned JW = 8;

    typedef logic [JW-1:0] jcode_t;

    function automatic jcode_t jc_next(input jcode_t code, input int unsigned n);
        return (code >> 1) | (jcode_t'(~code[0]) << (n - 1));
    endfunction

    // Rising half of the sequence fills from the MSB, falling half drains from it.
    function automatic int unsigned code_to_phase(input jcode_t code, input int unsigned n);
        jcode_t      top;
        int unsigned ones;
        top  = code >> (n - 1);
        ones = $countones(code);
        if (top[0])
            return ones;
        else if (ones == 0)
            return 0;
        else
            return 2 * n - ones;
    endfunction

    function automatic jcode_t phase_to_code(input int unsigned k, input int unsigned n);
        if (k <= n)
            return jcode_t'(((32'd1 << k) - 32'd1) << (n - k));
        else
            return jcode_t'((32'd1 << (2 * n - k)) - 32'd1);
    endfunction

    function automatic logic jc_legal(input jcode_t code, input int unsigned n);
        return phase_to_code(code_to_phase(code, n), n) == code;
    endfunction

endpackage

// File: rtl/jcnt_slot_timer.sv
// Johnson slot counter: run gating, illegal-code recovery to 0 and a load port
// for skipping ahead. Decodes owner and first-phase flag from the current code.
module jcnt_slot_timer
    import jcnt_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned OW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            load_en,
    input  logic [NREQ-1:0] load_code,
    output logic [NREQ-1:0] code,
    output logic [OW-1:0]   owner,
    output logic            first_phase,
    output logic            legal
);

    logic [NREQ-1:0] code_q;
    logic [NREQ-1:0] code_d;
    int unsigned     phase;

    always_comb begin
        legal       = jc_legal(jcode_t'(code_q), NREQ);
        phase       = code_to_phase(jcode_t'(code_q), NREQ);
        owner       = OW'(phase >> 1);
        first_phase = legal && (phase[0] == 1'b0);
        code_d      = code_q;
        if (run) begin
            if (!legal)
                code_d = '0;
            else if (load_en)
                code_d = load_code;
            else
                code_d = NREQ'(jc_next(jcode_t'(code_q), NREQ));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            code_q <= '0;
        else
            code_q <= code_d;
    end

    assign code = code_q;

endmodule

// File: rtl/jcnt_capture_sched.sv
// Slot-scheduled capture stage shared by NREQ requesters, one capture per slot.
// Define JCNT_SCHED_SKIP_EN for work-conserving mode (jump to next requesting slot).
module jcnt_capture_sched
    import jcnt_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       data_in,
    output logic [NREQ-1:0]          ack,
    output logic [DW-1:0]            data_out,
    output logic                     data_valid,
    output logic [$clog2(NREQ)-1:0]  src_id,
    output logic [NREQ-1:0]          jcnt_out
);

    localparam int unsigned OW = $clog2(NREQ);

    logic [OW-1:0]   owner;
    logic            first_phase;
    logic            legal;
    logic            load_en;
    logic [NREQ-1:0] load_code;
    logic            slot_used;
    logic            slot_used_d;
    logic            capture;
    logic [NREQ-1:0] ack_d;
    logic [DW-1:0]   word;

    jcnt_slot_timer #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .load_en     (load_en),
        .load_code   (load_code),
        .code        (jcnt_out),
        .owner       (owner),
        .first_phase (first_phase),
        .legal       (legal)
    );

    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner == OW'(i))
                word = data_in[i*DW +: DW];
        end
        capture = run && legal && req[owner] && !slot_used;
        ack_d   = '0;
        if (capture)
            ack_d[owner] = 1'b1;
        // Leaving the slot (second phase, skip load or recovery) frees it for the next owner.
        slot_used_d = slot_used;
        if (run) begin
            if (!legal || load_en || !first_phase)
                slot_used_d = 1'b0;
            else if (capture)
                slot_used_d = 1'b1;
        end
    end

    always_comb begin
        load_en   = 1'b0;
        load_code = '0;
`ifdef JCNT_SCHED_SKIP_EN
        begin
            logic [OW-1:0] cand;
            cand = '0;
            if (run && legal && !capture) begin
                for (int unsigned d = 1; d < NREQ; d++) begin
                    cand = OW'((32'(owner) + d) % NREQ);
                    if (!load_en && req[cand]) begin
                        load_en   = 1'b1;
                        load_code = NREQ'(phase_to_code(32'(cand) * 2, NREQ));
                    end
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_used  <= 1'b0;
            ack        <= '0;
            data_valid <= 1'b0;
            data_out   <= '0;
            src_id     <= '0;
        end else begin
            slot_used  <= slot_used_d;
            ack        <= ack_d;
            data_valid <= capture;
            if (capture) begin
                data_out <= word;
                src_id   <= owner;
            end
        end
    end

endmodule

// File: tb/tb_jcnt_capture_sched.sv
// Bench for jcnt_capture_sched: phase-level reference model, per-cycle compare,
// directed literal checks and randomized handshaking traffic with async resets.
module tb_jcnt_capture_sched;

    localparam int NREQ = 4;
    localparam int DW   = 4;
    localparam int NPH  = 2 * NREQ;
    localparam int SW   = $clog2(NREQ);
    localparam logic [NREQ-1:0] ILLEGAL = 4'b0101;

    typedef logic [NREQ*DW-1:0] bus_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              run = 1'b0;
    logic [NREQ-1:0]   req = '0;
    bus_t              data_in = '0;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     data_out;
    logic              data_valid;
    logic [SW-1:0]     src_id;
    logic [NREQ-1:0]   jcnt_out;

    int checks   = 0;
    int failures = 0;

    // Reference state: phase about to be evaluated, plus registered outputs.
    int              m_phase   = 0;
    bit              m_used    = 1'b0;
    bit              m_illegal = 1'b0;
    logic [NREQ-1:0] m_ack     = '0;
    logic            m_dv      = 1'b0;
    logic [DW-1:0]   m_dout    = '0;
    logic [SW-1:0]   m_src     = '0;

    jcnt_capture_sched #(
        .NREQ (NREQ),
        .DW   (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .src_id     (src_id),
        .jcnt_out   (jcnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Phase k of the Johnson sequence: k ones from the top, then drain from the top.
    function automatic logic [NREQ-1:0] code_of(input int k);
        int v;
        if (k <= NREQ)
            v = ((1 << k) - 1) << (NREQ - k);
        else
            v = (1 << (NPH - k)) - 1;
        return NREQ'(v);
    endfunction

    function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    task automatic set_word(input int i, input logic [DW-1:0] w);
        bus_t m;
        m = bus_t'({DW{1'b1}}) << (i * DW);
        data_in = (data_in & ~m) | (bus_t'(w) << (i * DW));
    endtask

    initial begin
        int  own;
        int  nph;
        bit  cap;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0; m_used = 1'b0; m_illegal = 1'b0;
                m_ack = '0; m_dv = 1'b0; m_dout = '0; m_src = '0;
            end else if (!run) begin
                m_ack = '0;
                m_dv  = 1'b0;
            end else if (m_illegal) begin
                m_illegal = 1'b0; m_phase = 0; m_used = 1'b0;
                m_ack = '0; m_dv = 1'b0;
            end else begin
                own   = m_phase / 2;
                cap   = bit_of(req, own) && !m_used;
                m_ack = '0;
                m_dv  = 1'b0;
                if (cap) begin
                    m_ack  = NREQ'(1) << own;
                    m_dv   = 1'b1;
                    m_dout = DW'(data_in >> (own * DW));
                    m_src  = SW'(own);
                end
                nph = (m_phase + 1) % NPH;
`ifdef JCNT_SCHED_SKIP_EN
                if (!cap) begin
                    for (int d = 1; d < NREQ; d++) begin
                        if (bit_of(req, (own + d) % NREQ)) begin
                            nph = 2 * ((own + d) % NREQ);
                            break;
                        end
                    end
                end
`endif
                if (nph / 2 != own)
                    m_used = 1'b0;
                else if (cap)
                    m_used = 1'b1;
                m_phase = nph;
            end
        end
    end

    always @(negedge clk) begin
        chk("jcnt_out",   32'(jcnt_out),   32'(m_illegal ? ILLEGAL : code_of(m_phase)));
        chk("ack",        32'(ack),        32'(m_ack));
        chk("data_valid", 32'(data_valid), 32'(m_dv));
        chk("data_out",   32'(data_out),   32'(m_dout));
        chk("src_id",     32'(src_id),     32'(m_src));
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_jcnt"}, 32'(jcnt_out),   32'd0);
        chk({tag, "_ack"},  32'(ack),        32'd0);
        chk({tag, "_dv"},   32'(data_valid), 32'd0);
        chk({tag, "_dout"}, 32'(data_out),   32'd0);
        chk({tag, "_src"},  32'(src_id),     32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int              t;
        bit              seen;
        logic [NREQ-1:0] r;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");

        // Single requester 1 with word 0xA.
        rst = 1'b0; run = 1'b1; req = 4'b0010; set_word(1, 4'hA);
`ifdef JCNT_SCHED_SKIP_EN
        repeat (2) @(negedge clk);
`else
        repeat (3) @(negedge clk);
`endif
        chk("t1_ack",  32'(ack),        32'h2);
        chk("t1_dout", 32'(data_out),   32'hA);
        chk("t1_src",  32'(src_id),     32'd1);
        chk("t1_dv",   32'(data_valid), 32'd1);
        chk("t1_jcnt", 32'(jcnt_out),   32'hE);
        req = '0;

        // Requester 0 held high: one ack per slot visit.
        req = 4'b0001; set_word(0, 4'h5);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = ack[0];
        end
        chk("held_first_ack", 32'(seen), 32'd1);
        seen = 1'b0; t = 0;
        while (!seen && t < 40) begin
            @(negedge clk);
            t++;
            seen = ack[0];
        end
`ifdef JCNT_SCHED_SKIP_EN
        chk("held_spacing", 32'(t), 32'd3);
`else
        chk("held_spacing", 32'(t), 32'd8);
`endif
        req = '0;

        // Freeze mid-slot of owner 2, then resume and capture in the same slot.
        t = 0;
        while (m_phase != 4 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("reach_phase4", 32'(m_phase), 32'd4);
        run = 1'b0; req = 4'b0100; set_word(2, 4'h7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("frozen_jcnt", 32'(jcnt_out), 32'hF);
            chk("frozen_ack",  32'(ack),      32'd0);
        end
        run = 1'b1;
        @(negedge clk);
        chk("resume_ack",  32'(ack),      32'h4);
        chk("resume_dout", 32'(data_out), 32'h7);
        req = '0;

        // Illegal code is recovered to 0 on the next run edge.
        @(posedge clk);
        #2;
        force dut.u_timer.code_q = ILLEGAL;
        m_illegal = 1'b1;
        #1;
        release dut.u_timer.code_q;
        @(negedge clk);
        @(negedge clk);
        chk("illegal_reload", 32'(jcnt_out), 32'd0);
        chk("illegal_no_ack", 32'(ack),      32'd0);

        // Randomized traffic with handshake and occasional async reset.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            run = ($urandom_range(0, 7) != 0);
            r = req;
            for (int i = 0; i < NREQ; i++) begin
                if (bit_of(r, i)) begin
                    if (bit_of(m_ack, i)) begin
                        if ($urandom_range(0, 1) == 0)
                            r = r & ~(NREQ'(1) << i);
                        else
                            set_word(i, DW'($urandom));
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    r = r | (NREQ'(1) << i);
                    set_word(i, DW'($urandom));
                end
            end
            req = r;
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                #1 chk_reset_outputs("async_rst");
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
